// File: rtl/pcie_tcap_pkg.sv
// ---------------------------------------------------------------------------
// pcie_tcap_pkg
// Shared types for the PCIe TLP-capture path.
//   tcap_dir_t       : 2-bit direction tag carried with every FIFO word
//   tcap_fifo_word_t : 76-bit capture-FIFO word
//                      {dir, tkeep[7:0], tdata[63:0], tlast, tuser}
//   tcap_state_t     : record-framing FSM states of tlp_tcap_mux
//   TCAP_FIFO_W      : capture-FIFO word width
// ---------------------------------------------------------------------------
package pcie_tcap_pkg;

  localparam int TCAP_FIFO_W = 76;

  typedef enum logic [1:0] {
    DIR_CQ = 2'd0,
    DIR_CC = 2'd1,
    DIR_RQ = 2'd2,
    DIR_RC = 2'd3
  } tcap_dir_t;

  typedef struct packed {
    tcap_dir_t   dir;
    logic [7:0]  tkeep;
    logic [63:0] tdata;
    logic        tlast;
    logic        tuser;
  } tcap_fifo_word_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PASS  = 2'd1,
    ST_PAD   = 2'd2,
    ST_DRAIN = 2'd3
  } tcap_state_t;

endpackage

// File: rtl/rr_arb4.sv
// ---------------------------------------------------------------------------
// rr_arb4
// Four-request round-robin arbiter. The winner is chosen combinationally by
// scanning upward (mod 4) from the priority pointer. The pointer moves to
// winner+1 on a clock edge where grant_en is high and a winner exists.
// Ports:
//   clk156     : clock
//   sys_rst_n  : asynchronous active-low reset (pointer -> request 0)
//   req[3:0]   : request vector
//   grant_en   : commit the current winner (advances the pointer)
//   gnt_idx    : index of the current winner (valid when gnt_vld)
//   gnt_vld    : at least one request is pending
// ---------------------------------------------------------------------------
module rr_arb4 (
  input  logic       clk156,
  input  logic       sys_rst_n,
  input  logic [3:0] req,
  input  logic       grant_en,
  output logic [1:0] gnt_idx,
  output logic       gnt_vld
);

  logic [1:0] ptr_reg;

  // Walk the offsets from farthest to nearest so the request closest to the
  // pointer is the last one to overwrite the result.
  always_comb begin
    gnt_idx = ptr_reg;
    gnt_vld = 1'b0;
    for (int k = 3; k >= 0; k--) begin
      if (req[ptr_reg + 2'(k)]) begin
        gnt_idx = ptr_reg + 2'(k);
        gnt_vld = 1'b1;
      end
    end
  end

  always_ff @(posedge clk156 or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      ptr_reg <= 2'd0;
    end else if (grant_en && gnt_vld) begin
      ptr_reg <= gnt_idx + 2'd1;
    end
  end

endmodule

// File: rtl/tlp_tcap_mux.sv
// ---------------------------------------------------------------------------
// tlp_tcap_mux
// Merges the four captured-TLP AXI-Stream channels (CQ, CC, RQ, RC) into one
// capture-FIFO write stream. Arbitration is packet-atomic round-robin. Every
// TLP becomes a record of exactly tlp_words FIFO words: short TLPs are padded
// with zero words (tkeep FF), and long TLPs are cut after tlp_words beats with
// the remainder accepted and discarded. Each word carries the direction code
// of its source channel.
// Ports:
//   clk156, sys_rst_n     : clock, asynchronous active-low reset
//   enable                : 0 blocks new grants; an in-flight record completes
//   s_<ch>_tvalid/tready/tdata/tkeep/tlast : per-channel AXI-Stream inputs
//   wr_en, din            : registered FIFO write strobe and 76-bit word
//   prog_full             : FIFO cannot take another full record (IDLE only)
//   pkt_cnt/trunc_cnt/pad_cnt : wrapping record/truncation/padding counters
// ---------------------------------------------------------------------------
module tlp_tcap_mux
  import pcie_tcap_pkg::*;
#(
  parameter int tlp_len   = 32,
  parameter int cnt_width = 32
) (
  input  logic                   clk156,
  input  logic                   sys_rst_n,
  input  logic                   enable,

  input  logic                   s_cq_tvalid,
  output logic                   s_cq_tready,
  input  logic [63:0]            s_cq_tdata,
  input  logic [7:0]             s_cq_tkeep,
  input  logic                   s_cq_tlast,

  input  logic                   s_cc_tvalid,
  output logic                   s_cc_tready,
  input  logic [63:0]            s_cc_tdata,
  input  logic [7:0]             s_cc_tkeep,
  input  logic                   s_cc_tlast,

  input  logic                   s_rq_tvalid,
  output logic                   s_rq_tready,
  input  logic [63:0]            s_rq_tdata,
  input  logic [7:0]             s_rq_tkeep,
  input  logic                   s_rq_tlast,

  input  logic                   s_rc_tvalid,
  output logic                   s_rc_tready,
  input  logic [63:0]            s_rc_tdata,
  input  logic [7:0]             s_rc_tkeep,
  input  logic                   s_rc_tlast,

  output logic                   wr_en,
  output logic [TCAP_FIFO_W-1:0] din,
  input  logic                   prog_full,

  output logic [cnt_width-1:0]   pkt_cnt,
  output logic [cnt_width-1:0]   trunc_cnt,
  output logic [cnt_width-1:0]   pad_cnt
);

  localparam int tlp_words = tlp_len / 8;
  localparam int WCNT_W    = (tlp_words > 1) ? $clog2(tlp_words) : 1;
  localparam logic [WCNT_W-1:0] LAST_WCNT = WCNT_W'(tlp_words - 1);

  // Channel inputs gathered into arrays indexed by direction code.
  logic [3:0]  tvalid_vec;
  logic [3:0]  tlast_vec;
  logic [3:0]  tready_vec;
  logic [63:0] tdata_arr [4];
  logic [7:0]  tkeep_arr [4];

  assign tvalid_vec = {s_rc_tvalid, s_rq_tvalid, s_cc_tvalid, s_cq_tvalid};
  assign tlast_vec  = {s_rc_tlast,  s_rq_tlast,  s_cc_tlast,  s_cq_tlast};
  assign tdata_arr[0] = s_cq_tdata;
  assign tdata_arr[1] = s_cc_tdata;
  assign tdata_arr[2] = s_rq_tdata;
  assign tdata_arr[3] = s_rc_tdata;
  assign tkeep_arr[0] = s_cq_tkeep;
  assign tkeep_arr[1] = s_cc_tkeep;
  assign tkeep_arr[2] = s_rq_tkeep;
  assign tkeep_arr[3] = s_rc_tkeep;

  assign s_cq_tready = tready_vec[0];
  assign s_cc_tready = tready_vec[1];
  assign s_rq_tready = tready_vec[2];
  assign s_rc_tready = tready_vec[3];

  // FSM state and registered outputs.
  tcap_state_t           state_reg;
  logic [1:0]            sel_reg;
  logic [WCNT_W-1:0]     wcnt_reg;
  logic                  wr_en_reg;
  tcap_fifo_word_t       din_reg;
  logic [cnt_width-1:0]  pkt_cnt_reg;
  logic [cnt_width-1:0]  trunc_cnt_reg;
  logic [cnt_width-1:0]  pad_cnt_reg;

  // Arbitration.
  logic [1:0] gnt_idx;
  logic       gnt_vld;
  logic       grant;

  assign grant = (state_reg == ST_IDLE) && enable && !prog_full && gnt_vld;

  rr_arb4 u_arb (
    .clk156    (clk156),
    .sys_rst_n (sys_rst_n),
    .req       (tvalid_vec),
    .grant_en  (grant),
    .gnt_idx   (gnt_idx),
    .gnt_vld   (gnt_vld)
  );

  // tready is a pure decode of registered state, so no input reaches it
  // combinationally. Only the selected channel is ready, and only while its
  // beats are being passed or drained.
  logic consuming;
  assign consuming = (state_reg == ST_PASS) || (state_reg == ST_DRAIN);

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_tready
      assign tready_vec[gi] = consuming && (sel_reg == 2'(gi));
    end
  endgenerate

  // Selected-channel view.
  logic        sel_valid;
  logic        sel_last;
  logic [63:0] sel_data;
  logic [7:0]  sel_keep;
  logic        last_word;

  assign sel_valid = tvalid_vec[sel_reg];
  assign sel_last  = tlast_vec[sel_reg];
  assign sel_data  = tdata_arr[sel_reg];
  assign sel_keep  = tkeep_arr[sel_reg];
  assign last_word = (wcnt_reg == LAST_WCNT);

  always_ff @(posedge clk156 or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_reg     <= ST_IDLE;
      sel_reg       <= 2'd0;
      wcnt_reg      <= '0;
      wr_en_reg     <= 1'b0;
      din_reg       <= '0;
      pkt_cnt_reg   <= '0;
      trunc_cnt_reg <= '0;
      pad_cnt_reg   <= '0;
    end else begin
      wr_en_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (grant) begin
            sel_reg   <= gnt_idx;
            wcnt_reg  <= '0;
            state_reg <= ST_PASS;
          end
        end

        ST_PASS: begin
          // tready is high for sel here, so tvalid alone means a handshake.
          if (sel_valid) begin
            wr_en_reg <= 1'b1;
            din_reg   <= '{dir:   tcap_dir_t'(sel_reg),
                           tkeep: sel_keep,
                           tdata: sel_data,
                           tlast: last_word,
                           tuser: 1'b0};
            wcnt_reg  <= wcnt_reg + 1'b1;
            if (last_word) begin
              pkt_cnt_reg <= pkt_cnt_reg + 1'b1;
              if (sel_last) begin
                state_reg <= ST_IDLE;
              end else begin
                // Record is full but the TLP goes on: swallow the tail.
                state_reg     <= ST_DRAIN;
                trunc_cnt_reg <= trunc_cnt_reg + 1'b1;
              end
            end else if (sel_last) begin
              state_reg   <= ST_PAD;
              pad_cnt_reg <= pad_cnt_reg + 1'b1;
            end
          end
        end

        ST_PAD: begin
          wr_en_reg <= 1'b1;
          din_reg   <= '{dir:   tcap_dir_t'(sel_reg),
                         tkeep: 8'hFF,
                         tdata: 64'd0,
                         tlast: last_word,
                         tuser: 1'b0};
          wcnt_reg  <= wcnt_reg + 1'b1;
          if (last_word) begin
            pkt_cnt_reg <= pkt_cnt_reg + 1'b1;
            state_reg   <= ST_IDLE;
          end
        end

        ST_DRAIN: begin
          if (sel_valid && sel_last) begin
            state_reg <= ST_IDLE;
          end
        end

        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign wr_en     = wr_en_reg;
  assign din       = din_reg;
  assign pkt_cnt   = pkt_cnt_reg;
  assign trunc_cnt = trunc_cnt_reg;
  assign pad_cnt   = pad_cnt_reg;

endmodule

// File: tb/tb_tlp_tcap_mux.sv
// ---------------------------------------------------------------------------
// tb_tlp_tcap_mux
// Self-checking bench for tlp_tcap_mux. Per-channel beat sources feed the
// DUT; every submitted TLP also produces its expected 4-word record from the
// framing rules (copy up to 4 beats, zero/FF padding, tlast on word 3). FIFO
// writes are grouped into records and matched against the head record of the
// channel named by their dir field.
// ---------------------------------------------------------------------------
module tb_tlp_tcap_mux;
  import pcie_tcap_pkg::*;

  localparam int TW = 4;

  logic clk156 = 1'b0;
  always #3 clk156 = ~clk156;

  logic        sys_rst_n, enable, prog_full;
  logic [3:0]  tv, tl;
  logic [63:0] td [4];
  logic [7:0]  tk [4];
  logic        tr_cq, tr_cc, tr_rq, tr_rc;
  logic [3:0]  tr;
  logic        wr_en;
  logic [75:0] din;
  logic [31:0] pkt_cnt, trunc_cnt, pad_cnt;

  assign tr = {tr_rc, tr_rq, tr_cc, tr_cq};

  tlp_tcap_mux #(.tlp_len(32), .cnt_width(32)) dut (
    .clk156(clk156), .sys_rst_n(sys_rst_n), .enable(enable),
    .s_cq_tvalid(tv[0]), .s_cq_tready(tr_cq), .s_cq_tdata(td[0]), .s_cq_tkeep(tk[0]), .s_cq_tlast(tl[0]),
    .s_cc_tvalid(tv[1]), .s_cc_tready(tr_cc), .s_cc_tdata(td[1]), .s_cc_tkeep(tk[1]), .s_cc_tlast(tl[1]),
    .s_rq_tvalid(tv[2]), .s_rq_tready(tr_rq), .s_rq_tdata(td[2]), .s_rq_tkeep(tk[2]), .s_rq_tlast(tl[2]),
    .s_rc_tvalid(tv[3]), .s_rc_tready(tr_rc), .s_rc_tdata(td[3]), .s_rc_tkeep(tk[3]), .s_rc_tlast(tl[3]),
    .wr_en(wr_en), .din(din), .prog_full(prog_full),
    .pkt_cnt(pkt_cnt), .trunc_cnt(trunc_cnt), .pad_cnt(pad_cnt)
  );

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
  } beat_t;

  typedef struct {
    int         ch;
    int         nbeats;
    logic [7:0] last_keep;
    int         exp_pad;
    int         exp_trunc;
  } vec_t;

  beat_t           src_mem [4][512];
  int              src_wr [4];
  int              src_rd [4];
  tcap_fifo_word_t exp_mem [4][256];
  int              exp_wr [4];
  int              exp_rd [4];
  tcap_fifo_word_t wlog [2048];
  int              wcount = 0;
  int              chk_idx;
  int              rec_dirs [512];
  int              rec_n;
  int              exp_pkt, exp_pad, exp_trunc;
  int              checks, failures;
  int              gap_pct;
  logic            flush;

  // Source driver: present the head beat, with random valid gaps.
  always @(negedge clk156) begin
    for (int c = 0; c < 4; c++) begin
      if (src_rd[c] < src_wr[c] && $urandom_range(99) >= gap_pct) begin
        tv[c] = 1'b1;
        td[c] = src_mem[c][src_rd[c]].data;
        tk[c] = src_mem[c][src_rd[c]].keep;
        tl[c] = src_mem[c][src_rd[c]].last;
      end else begin
        tv[c] = 1'b0;
        td[c] = 64'd0;
        tk[c] = 8'd0;
        tl[c] = 1'b0;
      end
    end
  end

  // Handshake: pop accepted beats; flush discards everything queued.
  always @(posedge clk156) begin
    for (int c = 0; c < 4; c++) begin
      if (flush) src_rd[c] = src_wr[c];
      else if (tv[c] && tr[c]) src_rd[c] = src_rd[c] + 1;
    end
  end

  // FIFO write monitor.
  always @(negedge clk156) begin
    if (sys_rst_n && wr_en) begin
      if (wcount < 2048) wlog[wcount] = din;
      wcount = wcount + 1;
    end
  end

  task automatic tick();
    @(negedge clk156);
    #1;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Queue a TLP on channel c and append its expected record.
  task automatic send_tlp(input int c, input int n, input logic [7:0] last_keep);
    beat_t b [8];
    tcap_fifo_word_t w;
    for (int i = 0; i < n; i++) begin
      b[i].data = {$urandom, $urandom};
      b[i].keep = (i == n - 1) ? last_keep : 8'hFF;
      b[i].last = (i == n - 1);
      src_mem[c][src_wr[c]] = b[i];
      src_wr[c]++;
    end
    for (int i = 0; i < TW; i++) begin
      w.dir   = tcap_dir_t'(c);
      w.tkeep = (i < n) ? b[i].keep : 8'hFF;
      w.tdata = (i < n) ? b[i].data : 64'd0;
      w.tlast = (i == TW - 1);
      w.tuser = 1'b0;
      exp_mem[c][exp_wr[c]] = w;
      exp_wr[c]++;
    end
    exp_pkt++;
    if (n < TW) exp_pad++;
    if (n > TW) exp_trunc++;
  endtask

  task automatic check_records();
    while (chk_idx + TW <= wcount) begin
      int d;
      d = int'(wlog[chk_idx].dir);
      rec_dirs[rec_n] = d;
      rec_n++;
      for (int i = 0; i < TW; i++) begin
        chk("rec_dir_const", 128'(wlog[chk_idx + i].dir), 128'(d));
        if (exp_rd[d] + i < exp_wr[d]) begin
          chk("rec_word", 128'(wlog[chk_idx + i]), 128'(exp_mem[d][exp_rd[d] + i]));
        end else begin
          checks++;
          failures++;
          $display("FAIL rec_unexpected dir=%0d word=%0h required=none", d, wlog[chk_idx + i]);
        end
      end
      exp_rd[d] += TW;
      chk_idx += TW;
    end
  endtask

  task automatic wait_done(input int budget, input bit rnd);
    int  cyc;
    int  pend;
    bit  done;
    cyc  = 0;
    done = 0;
    while (!done && cyc < budget) begin
      if (rnd) begin
        enable    = ($urandom_range(9) != 0);
        prog_full = ($urandom_range(4) == 0);
      end
      tick();
      cyc++;
      pend = 0;
      done = 1;
      for (int c = 0; c < 4; c++) begin
        pend += exp_wr[c] - exp_rd[c];
        if (src_rd[c] != src_wr[c]) done = 0;
      end
      if (wcount - chk_idx != pend) done = 0;
    end
    enable    = 1'b1;
    prog_full = 1'b0;
    chk("wait_done", 128'(done), 128'd1);
    repeat (3) tick();
    check_records();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  vec_t tbl [7];

  initial begin
    int ref_pkt, ref_pad, ref_trunc, rec_before, nwait;
    sys_rst_n = 1'b0; enable = 1'b1; prog_full = 1'b0; gap_pct = 0; flush = 1'b0;
    checks = 0; failures = 0; chk_idx = 0; rec_n = 0;
    exp_pkt = 0; exp_pad = 0; exp_trunc = 0;
    for (int c = 0; c < 4; c++) begin
      src_wr[c] = 0; src_rd[c] = 0; exp_wr[c] = 0; exp_rd[c] = 0;
    end
    for (int i = 0; i < 512; i++) rec_dirs[i] = -1;

    tbl[0] = '{0, 4, 8'h0F, 0, 0};
    tbl[1] = '{3, 2, 8'hFF, 1, 0};
    tbl[2] = '{2, 6, 8'hFF, 0, 1};
    tbl[3] = '{1, 1, 8'h01, 1, 0};
    tbl[4] = '{3, 5, 8'h7F, 0, 1};
    tbl[5] = '{0, 3, 8'h03, 1, 0};
    tbl[6] = '{1, 4, 8'hFF, 0, 0};

    repeat (3) tick();
    chk("rst_wr_en", 128'(wr_en), 128'd0);
    chk("rst_din", 128'(din), 128'd0);
    chk("rst_tready", 128'(tr), 128'd0);
    chk("rst_pkt_cnt", 128'(pkt_cnt), 128'd0);
    chk("rst_trunc_cnt", 128'(trunc_cnt), 128'd0);
    chk("rst_pad_cnt", 128'(pad_cnt), 128'd0);

    // All four channels valid from reset: strict rotation.
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 4; c++) send_tlp(c, 4, 8'hFF);
    tick();
    sys_rst_n = 1'b1;
    wait_done(400, 0);
    for (int k = 0; k < 8; k++) chk("rr_order", 128'(rec_dirs[k]), 128'(k % 4));
    chk("rr_pkt_cnt", 128'(pkt_cnt), 128'(exp_pkt));

    // Table-driven single-TLP vectors.
    ref_pkt = exp_pkt; ref_pad = exp_pad; ref_trunc = exp_trunc;
    for (int v = 0; v < 7; v++) begin
      rec_before = rec_n;
      send_tlp(tbl[v].ch, tbl[v].nbeats, tbl[v].last_keep);
      wait_done(200, 0);
      ref_pkt   += 1;
      ref_pad   += tbl[v].exp_pad;
      ref_trunc += tbl[v].exp_trunc;
      chk("vec_records", 128'(rec_n), 128'(rec_before + 1));
      chk("vec_dir", 128'(rec_dirs[rec_before]), 128'(tbl[v].ch));
      chk("vec_pkt_cnt", 128'(pkt_cnt), 128'(ref_pkt));
      chk("vec_pad_cnt", 128'(pad_cnt), 128'(ref_pad));
      chk("vec_trunc_cnt", 128'(trunc_cnt), 128'(ref_trunc));
      chk("vec_tready_idle", 128'(tr), 128'd0);
      $display("vector %0d ch=%0d beats=%0d pkt=%0d pad=%0d trunc=%0d", v, tbl[v].ch,
               tbl[v].nbeats, pkt_cnt, pad_cnt, trunc_cnt);
    end

    // prog_full holds off the grant; release timing.
    prog_full = 1'b1;
    nwait = wcount;
    send_tlp(1, 4, 8'h3F);
    repeat (6) begin
      tick();
      chk("pf_tready", 128'(tr), 128'd0);
      chk("pf_wr_en", 128'(wr_en), 128'd0);
    end
    chk("pf_no_writes", 128'(wcount), 128'(nwait));
    prog_full = 1'b0;
    tick();
    chk("pf_grant", 128'(tr), 128'b0010);
    chk("pf_grant_nowrite", 128'(wr_en), 128'd0);
    tick();
    chk("pf_first_write", 128'(wr_en), 128'd1);
    chk("pf_first_dir", 128'(din[75:74]), 128'd1);
    wait_done(200, 0);

    // Reset in the middle of a PASS record.
    send_tlp(2, 8, 8'hFF);
    nwait = 0;
    while (!tr[2] && nwait < 50) begin
      tick();
      nwait++;
    end
    chk("rst_mid_grant", 128'(tr[2]), 128'd1);
    tick();
    sys_rst_n = 1'b0;
    #1;
    chk("rst_mid_wr_en", 128'(wr_en), 128'd0);
    chk("rst_mid_din", 128'(din), 128'd0);
    chk("rst_mid_tready", 128'(tr), 128'd0);
    chk("rst_mid_pkt_cnt", 128'(pkt_cnt), 128'd0);
    chk("rst_mid_pad_cnt", 128'(pad_cnt), 128'd0);
    chk("rst_mid_trunc_cnt", 128'(trunc_cnt), 128'd0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk_idx = wcount;
    for (int c = 0; c < 4; c++) exp_rd[c] = exp_wr[c];
    exp_pkt = 0; exp_pad = 0; exp_trunc = 0;
    send_tlp(3, 4, 8'hFF);
    send_tlp(0, 3, 8'h01);
    tick();
    sys_rst_n = 1'b1;
    rec_before = rec_n;
    wait_done(200, 0);
    chk("rst_rr_first", 128'(rec_dirs[rec_before]), 128'd0);
    chk("rst_rr_second", 128'(rec_dirs[rec_before + 1]), 128'd3);
    chk("rst_after_pkt", 128'(pkt_cnt), 128'd2);
    chk("rst_after_pad", 128'(pad_cnt), 128'd1);

    // Randomized traffic with gaps, enable and prog_full toggling.
    gap_pct = 30;
    for (int i = 0; i < 60; i++)
      send_tlp(int'($urandom_range(3)), int'($urandom_range(7, 1)), 8'($urandom_range(255)));
    wait_done(20000, 1);
    chk("rnd_pkt_cnt", 128'(pkt_cnt), 128'(exp_pkt));
    chk("rnd_pad_cnt", 128'(pad_cnt), 128'(exp_pad));
    chk("rnd_trunc_cnt", 128'(trunc_cnt), 128'(exp_trunc));
    chk("rnd_word_total", 128'(wcount - chk_idx), 128'd0);
    $display("random phase pkt=%0d pad=%0d trunc=%0d", pkt_cnt, pad_cnt, trunc_cnt);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
